// File: rtl/cache_port_arbiter.sv
// Two-requester front end for the cache CPU-side port: round-robin grant, one
// transaction in flight, request fields latched at grant, per-transaction watchdog.
module cache_port_arbiter #(
  parameter int TIMEOUT_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH    = 32
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     p0_req,
  input  logic [ADDR_BITWIDTH-1:0] p0_addr,
  output logic [31:0]              p0_rdata,
  output logic                     p0_done,
  input  logic                     p1_req,
  input  logic [ADDR_BITWIDTH-1:0] p1_addr,
  input  logic [31:0]              p1_wdata,
  input  logic [3:0]               p1_we,
  output logic [31:0]              p1_rdata,
  output logic                     p1_done,
  output logic [ADDR_BITWIDTH-1:0] c_address,
  output logic [31:0]              c_data_in,
  output logic [3:0]               c_write_enable,
  input  logic [31:0]              c_data_out,
  input  logic                     c_data_out_ready,
  input  logic                     c_busy,
  output logic                     grant,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [TIMEOUT_BITWIDTH-1:0] WD_MAX = '1;

  state_t                      state;
  logic [TIMEOUT_BITWIDTH-1:0] watchdog;

  logic        pick;
  logic        hit;
  logic        expire;
  logic [31:0] cmpl_data;

  // On a tie the port that did not own the last transaction wins.
  always_comb begin
    pick      = (p0_req && p1_req) ? ~grant : p1_req;
    hit       = !c_busy && c_data_out_ready;
    expire    = !hit && (watchdog == WD_MAX - 1'b1);
    cmpl_data = hit ? c_data_out : 32'hDEAD_BEEF;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= S_IDLE;
      watchdog       <= '0;
      c_address      <= '0;
      c_data_in      <= '0;
      c_write_enable <= '0;
      p0_done        <= 1'b0;
      p1_done        <= 1'b0;
      p0_rdata       <= '0;
      p1_rdata       <= '0;
      grant          <= 1'b1;
      timeout_err    <= 1'b0;
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (p0_req || p1_req) begin
            grant <= pick;
            if (pick) begin
              c_address      <= p1_addr;
              c_data_in      <= p1_wdata;
              c_write_enable <= p1_we;
            end else begin
              c_address      <= p0_addr;
              c_data_in      <= '0;
              c_write_enable <= '0;
            end
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          watchdog <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          watchdog <= watchdog + 1'b1;
          // Expiry completes the transaction with a poison word so the requester never hangs.
          if (hit || expire) begin
            c_write_enable <= '0;
            state          <= S_DONE;
            if (expire) timeout_err <= 1'b1;
            if (grant) begin
              p1_rdata <= cmpl_data;
              p1_done  <= 1'b1;
            end else begin
              p0_rdata <= cmpl_data;
              p0_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single cache CPU-side port (address, data_in, write_enable, data_out, data_out_ready, busy) between two requesters: port 0 (instruction fetch, read-only) and port 1 (data load/store).
- Round-robin grant, one transaction in flight, request fields latched at grant.
- Per-transaction watchdog; reports an error if the cache never completes.
- Sits between the core/test sequencer and the cache; the cache's burst-RAM side is untouched.

Parameters:
- TIMEOUT_BITWIDTH, 8, width of the watchdog counter; timeout fires after 2^TIMEOUT_BITWIDTH-1 cycles in WAIT.
- ADDR_BITWIDTH, 32, requester and cache address width.

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous active-low reset
- p0_req  in  1  port 0 read request, held until p0_done
- p0_addr  in  ADDR_BITWIDTH  port 0 byte address (word-aligned)
- p0_rdata  out  32  port 0 read data, valid while p0_done=1
- p0_done  out  1  one-cycle completion pulse
- p1_req  in  1  port 1 request, held until p1_done
- p1_addr  in  ADDR_BITWIDTH  port 1 byte address
- p1_wdata  in  32  port 1 write data
- p1_we  in  4  port 1 byte write enables; 0 = read
- p1_rdata  out  32  port 1 read data, valid while p1_done=1
- p1_done  out  1  one-cycle completion pulse
- c_address  out  ADDR_BITWIDTH  to cache address
- c_data_in  out  32  to cache data_in
- c_write_enable  out  4  to cache write_enable
- c_data_out  in  32  from cache data_out
- c_data_out_ready  in  1  from cache: data_out valid, or write committed, for c_address
- c_busy  in  1  from cache: line fetch/eviction in progress
- grant  out  1  owner of the current or last transaction (0/1)
- timeout_err  out  1  sticky; set on watchdog expiry

Behaviour:
- Reset (async, sys_rst_n=0): state=IDLE; c_address=0, c_data_in=0, c_write_enable=0; p0_done=p1_done=0; p0_rdata=p1_rdata=0; grant=1, so port 0 wins the first tie; timeout_err=0; watchdog=0.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - One requester active: grant it.
  - Both active: grant the port that is not the current grant value (round-robin).
  - On grant: latch addr; for port 1 also latch wdata/we, for port 0 force we=0. Drive the c_* outputs from the latched values and go to ISSUE.
- ISSUE: one-cycle settle, so the cache sees stable address and enables. Watchdog clears. Go to WAIT.
- WAIT:
  - Increment watchdog each cycle.
  - Complete when c_busy=0 and c_data_out_ready=1: capture c_data_out into the granted port's rdata, clear c_write_enable to 0 in the same edge, go to DONE.
  - If the watchdog reaches all-ones before completion: set timeout_err, clear c_write_enable, pulse done on the granted port with rdata=32'hDEAD_BEEF, go to DONE.
- DONE:
  - Granted port's done=1 for exactly this cycle; rdata holds until that port's next completion.
  - Next cycle: IDLE.
  - A requester must drop req in the cycle after done, otherwise a new request is taken, which is legal for back-to-back traffic.
- Latency: minimum 3 cycles from req sampled in IDLE to done (grant edge, ISSUE, WAIT hit, then done asserted). Cache misses extend WAIT.
- Arbitration is evaluated only in IDLE. Requests arriving mid-transaction wait; no preemption.
- Request fields may change after grant without effect, because they were latched.
- c_write_enable is non-zero only in ISSUE/WAIT of a port-1 write. It is never non-zero in IDLE or DONE, so no duplicate writes occur.
- timeout_err clears only on reset.
- Reset mid-transaction: all outputs return to reset values immediately; no done pulse is emitted.
- Simultaneous p0/p1 every cycle: grants strictly alternate 0,1,0,1…

Test Plan:
- Single read: after reset, p0_req=1, p0_addr=0x10; cache returns 0x1234_5678 with data_out_ready one cycle into WAIT -> p0_done pulses once, 3 cycles after req, p0_rdata=0x1234_5678; c_write_enable stays 0.
- Write then readback on port 1: write addr 0x8, wdata 0xCAFE_F00D, we=4'b1111, then read addr 0x8 with we=0 -> c_write_enable=1111 only during ISSUE/WAIT of the first transaction; the second read returns 0xCAFE_F00D.
- Contention: p0_req and p1_req held high for 6 transactions -> grant sequence 0,1,0,1,0,1; done pulses alternate; no transaction is lost.
- Miss stall: cache holds c_busy=1 for 20 cycles -> done is delayed by 20 cycles, c_address stays stable throughout, timeout_err=0.
- Watchdog: cache never asserts data_out_ready, TIMEOUT_BITWIDTH=4 -> done fires after 15 WAIT cycles, rdata=0xDEADBEEF, timeout_err=1 and stays set.
- Reset mid-WAIT of a write: deassert sys_rst_n -> c_write_enable=0 asynchronously, no done pulse, grant=1; the next request from port 0 is served normally.
